// File: rtl/game_controller.sv
// game_controller: 4x4 sliding-tile game engine. Moves are applied to a private
// working board one line per cycle, a new tile is spawned, and the result is
// published to the display board only during vertical blanking.
module game_controller #(
   parameter int WIN_VALUE = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic [4:0]  rng,
   input  logic        vblank,
   input  logic        load,
   input  logic [63:0] load_grid,
   output logic [63:0] grid,
   output logic        busy,
   output logic        won
);

   typedef enum logic [1:0] {IDLE, SLIDE, SPAWN, COMMIT} state_t;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   localparam logic [4:0] WIN_THR = 5'(WIN_VALUE);

   state_t      state_q, state_d;
   dir_t        dir_q, dir_d;
   logic [1:0]  line_q, line_d;
   logic        changed_q, changed_d;
   logic [63:0] work_q, work_d;
   logic [63:0] grid_q, grid_d;
   logic        won_q, won_d;
   logic [1:0]  init_q, init_d;
   logic        first_q, first_d;
   logic [3:0]  ptr_q, ptr_d;
   logic        val_q, val_d;
   logic [3:0]  scan_q, scan_d;

   logic [15:0] line_in, line_out;
   logic [3:0]  idx;
   logic [3:0]  spawn_ptr;
   logic        spawn_val;
   logic [3:0]  scan_cur;

   // Merged exponent, pinned at the largest value a nibble can hold.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'd15) ? 4'd15 : v + 4'd1;
   endfunction

   // Board cell holding element k of line ln for a given move direction.
   function automatic logic [3:0] cell_index(input dir_t d, input logic [1:0] ln,
                                             input logic [1:0] k);
      case (d)
         DIR_LEFT:  return {ln, k};
         DIR_RIGHT: return {ln, ~k};
         DIR_UP:    return {k, ln};
         default:   return {~k, ln};
      endcase
   endfunction

   // Compress toward element 0, then merge equal neighbours once each.
   function automatic logic [15:0] slide_line(input logic [15:0] in);
      logic [19:0] comp;
      logic [15:0] res;
      logic [3:0]  cur, nxt;
      logic [2:0]  j;
      logic        skip;
      comp = 20'd0;
      for (int i = 3; i >= 0; i--) begin
         if (in[4*i +: 4] != 4'd0) comp = {comp[15:0], in[4*i +: 4]};
      end
      res  = 16'd0;
      j    = 3'd0;
      skip = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cur = comp[4*i +: 4];
         nxt = comp[4*i+4 +: 4];
         if (skip) begin
            skip = 1'b0;
         end else if (cur != 4'd0) begin
            if (cur == nxt) begin
               res  = res | ({12'd0, sat_inc(cur)} << {j, 2'b00});
               skip = 1'b1;
            end else begin
               res = res | ({12'd0, cur} << {j, 2'b00});
            end
            j = j + 3'd1;
         end
      end
      return res;
   endfunction

   // True when any cell has reached the winning exponent.
   function automatic logic has_win(input logic [63:0] b);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if ({1'b0, b[4*c +: 4]} >= WIN_THR) hit = 1'b1;
      end
      return hit;
   endfunction

   // State and datapath registers; reset restarts the two initial spawns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SPAWN;
         dir_q     <= DIR_UP;
         line_q    <= 2'd0;
         changed_q <= 1'b0;
         work_q    <= 64'd0;
         grid_q    <= 64'd0;
         won_q     <= 1'b0;
         init_q    <= 2'd2;
         first_q   <= 1'b1;
         ptr_q     <= 4'd0;
         val_q     <= 1'b0;
         scan_q    <= 4'd0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         line_q    <= line_d;
         changed_q <= changed_d;
         work_q    <= work_d;
         grid_q    <= grid_d;
         won_q     <= won_d;
         init_q    <= init_d;
         first_q   <= first_d;
         ptr_q     <= ptr_d;
         val_q     <= val_d;
         scan_q    <= scan_d;
      end
   end

   // Next-state logic: move acceptance, line processing, spawn scan, commit.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      line_d    = line_q;
      changed_d = changed_q;
      work_d    = work_q;
      grid_d    = grid_q;
      won_d     = won_q;
      init_d    = init_q;
      first_d   = first_q;
      ptr_d     = ptr_q;
      val_d     = val_q;
      scan_d    = scan_q;
      line_in   = 16'd0;
      line_out  = 16'd0;
      idx       = 4'd0;
      spawn_ptr = 4'd0;
      spawn_val = 1'b0;
      scan_cur  = 4'd0;
      case (state_q)
         IDLE: begin
            if (load) begin
               work_d = load_grid;
               grid_d = load_grid;
            end else if (btn_up || btn_down || btn_left || btn_right) begin
               if (btn_up)        dir_d = DIR_UP;
               else if (btn_down) dir_d = DIR_DOWN;
               else if (btn_left) dir_d = DIR_LEFT;
               else               dir_d = DIR_RIGHT;
               line_d    = 2'd0;
               changed_d = 1'b0;
               state_d   = SLIDE;
            end
         end
         SLIDE: begin
            for (int k = 0; k < 4; k++) begin
               idx = cell_index(dir_q, line_q, 2'(k));
               line_in[4*k +: 4] = work_q[{idx, 2'b00} +: 4];
            end
            line_out = slide_line(line_in);
            for (int k = 0; k < 4; k++) begin
               idx = cell_index(dir_q, line_q, 2'(k));
               work_d[{idx, 2'b00} +: 4] = line_out[4*k +: 4];
            end
            changed_d = changed_q | (line_out != line_in);
            line_d    = line_q + 2'd1;
            if (line_q == 2'd3) begin
               if (changed_d) begin
                  state_d = SPAWN;
                  first_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         SPAWN: begin
            // rng is taken in the first cycle of each spawn, then held.
            spawn_ptr = first_q ? rng[3:0] : ptr_q;
            spawn_val = first_q ? rng[4] : val_q;
            scan_cur  = first_q ? 4'd0 : scan_q;
            first_d   = 1'b0;
            if (work_q[{spawn_ptr, 2'b00} +: 4] == 4'd0) begin
               work_d[{spawn_ptr, 2'b00} +: 4] = spawn_val ? 4'd2 : 4'd1;
               state_d = COMMIT;
            end else if (scan_cur == 4'd15) begin
               state_d = COMMIT;
            end else begin
               ptr_d  = spawn_ptr + 4'd1;
               val_d  = spawn_val;
               scan_d = scan_cur + 4'd1;
            end
         end
         COMMIT: begin
            if (vblank) begin
               grid_d = work_q;
               won_d  = won_q | has_win(work_q);
               init_d = (init_q == 2'd0) ? 2'd0 : init_q - 2'd1;
               if (init_d != 2'd0) begin
                  state_d = SPAWN;
                  first_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grid = grid_q;
   assign busy = (state_q != IDLE);
   assign won  = won_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed vector table, multi-cycle corner
// sequences, and random boards checked against a queue-based board model.
module tb_game_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_up, btn_down, btn_left, btn_right;
   logic [4:0]  rng;
   logic        vblank;
   logic        load;
   logic [63:0] load_grid;
   logic [63:0] grid;
   logic        busy;
   logic        won;

   int n_cmp = 0;
   int n_err = 0;
   localparam int LIMIT = 200;

   game_controller #(.WIN_VALUE(11)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .rng(rng), .vblank(vblank), .load(load), .load_grid(load_grid),
      .grid(grid), .busy(busy), .won(won)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] ld;
      logic [4:0]  rn;
      logic [3:0]  btn;     // {up, down, left, right}
      logic [63:0] exp_grid;
      int          exp_busy;
      logic        exp_won;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
      end
   endtask

   // Count cycles with busy high, starting at the current falling edge.
   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy !== 1'b0 && cnt < LIMIT) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [63:0] g);
      @(negedge clk);
      load = 1'b1;
      load_grid = g;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic do_move(input logic [3:0] b, output int cnt);
      @(negedge clk);
      {btn_up, btn_down, btn_left, btn_right} = b;
      @(negedge clk);
      {btn_up, btn_down, btn_left, btn_right} = 4'b0;
      wait_idle(cnt);
   endtask

   // Reference: apply a move line by line using queues.
   // dir: 0 up, 1 down, 2 left, 3 right.
   function automatic logic [63:0] ref_move(input logic [63:0] g, input int dir);
      logic [63:0] res;
      logic [3:0]  q[$];
      logic [3:0]  o[$];
      logic [3:0]  a;
      int          pos[4];
      int          r, c;
      res = g;
      for (int ln = 0; ln < 4; ln++) begin
         q.delete();
         o.delete();
         for (int k = 0; k < 4; k++) begin
            case (dir)
               0:       begin r = k;     c = ln;    end
               1:       begin r = 3 - k; c = ln;    end
               2:       begin r = ln;    c = k;     end
               default: begin r = ln;    c = 3 - k; end
            endcase
            pos[k] = r * 4 + c;
            if (g[pos[k]*4 +: 4] != 4'd0) q.push_back(g[pos[k]*4 +: 4]);
         end
         while (q.size() > 0) begin
            a = q.pop_front();
            if (q.size() > 0 && q[0] == a) begin
               void'(q.pop_front());
               o.push_back((a == 4'd15) ? 4'd15 : a + 4'd1);
            end else begin
               o.push_back(a);
            end
         end
         while (o.size() < 4) o.push_back(4'd0);
         for (int k = 0; k < 4; k++) res[pos[k]*4 +: 4] = o[k];
      end
      return res;
   endfunction

   function automatic logic [63:0] ref_spawn(input logic [63:0] g, input logic [4:0] rn,
                                             output int scans);
      int c;
      scans = 16;
      for (int i = 0; i < 16; i++) begin
         c = (int'(rn[3:0]) + i) % 16;
         if (g[c*4 +: 4] == 4'd0) begin
            g[c*4 +: 4] = rn[4] ? 4'd2 : 4'd1;
            scans = i + 1;
            return g;
         end
      end
      return g;
   endfunction

   function automatic logic ref_win(input logic [63:0] g);
      for (int c = 0; c < 16; c++) if (g[c*4 +: 4] >= 4'd11) return 1'b1;
      return 1'b0;
   endfunction

   vec_t        tbl[9];
   int          cnt;
   logic [63:0] b, mv, exp_g;
   logic [4:0]  rn;
   logic [3:0]  bt;
   int          d, sc, eb, r;
   logic        won_exp;

   initial begin
      tbl[0] = '{64'h2211, 5'h04, 4'b0010, 64'h0001_0032, 6, 1'b0};
      tbl[1] = '{64'h1111, 5'h14, 4'b0001, 64'h0002_2200, 6, 1'b0};
      tbl[2] = '{64'h1,    5'h00, 4'b0010, 64'h1,         4, 1'b0};
      tbl[3] = '{64'h0001_0010, 5'h00, 4'b1010, 64'h111, 8, 1'b0};
      tbl[4] = '{64'h0201, 5'h1F, 4'b0100, 64'h2201_0000_0000_0000, 6, 1'b0};
      tbl[5] = '{64'h0211, 5'h00, 4'b0010, 64'h122,       8, 1'b0};
      tbl[6] = '{64'hAA,   5'h00, 4'b0010, 64'h1B,        7, 1'b1};
      tbl[7] = '{64'hFF,   5'h00, 4'b0010, 64'h1F,        7, 1'b1};
      tbl[8] = '{64'h1,    5'h00, 4'b0010, 64'h1,         4, 1'b1};

      rst_n = 1'b0;
      {btn_up, btn_down, btn_left, btn_right} = 4'b0;
      rng = 5'h00;
      vblank = 1'b1;
      load = 1'b0;
      load_grid = 64'd0;

      // Reset state and the two initial spawn/commit passes.
      repeat (2) @(negedge clk);
      check("rst grid", grid, 64'd0);
      check("rst busy", {63'd0, busy}, 64'd1);
      check("rst won", {63'd0, won}, 64'd0);
      rst_n = 1'b1;
      wait_idle(cnt);
      check("init busy cycles", 64'(cnt), 64'd5);
      check("init grid", grid, 64'h11);
      check("init won", {63'd0, won}, 64'd0);

      // Directed vector table.
      for (int t = 0; t < 9; t++) begin
         rng = tbl[t].rn;
         do_load(tbl[t].ld);
         check($sformatf("v%0d load", t), grid, tbl[t].ld);
         do_move(tbl[t].btn, cnt);
         check($sformatf("v%0d busy cycles", t), 64'(cnt), 64'(tbl[t].exp_busy));
         check($sformatf("v%0d grid", t), grid, tbl[t].exp_grid);
         check($sformatf("v%0d won", t), {63'd0, won}, {63'd0, tbl[t].exp_won});
      end

      // Commit stalls until vblank; inputs while busy are dropped.
      rng = 5'h00;
      vblank = 1'b0;
      do_load(64'h0003_0000_0003_0000);
      @(negedge clk);
      btn_up = 1'b1;
      @(negedge clk);
      btn_up = 1'b0;
      repeat (12) @(negedge clk);
      check("hold busy", {63'd0, busy}, 64'd1);
      check("hold grid", grid, 64'h0003_0000_0003_0000);
      load = 1'b1;
      load_grid = 64'hDEAD;
      btn_down = 1'b1;
      @(negedge clk);
      load = 1'b0;
      btn_down = 1'b0;
      repeat (3) @(negedge clk);
      check("hold grid 2", grid, 64'h0003_0000_0003_0000);
      vblank = 1'b1;
      wait_idle(cnt);
      check("hold release", 64'(cnt < LIMIT), 64'd1);
      check("hold final grid", grid, 64'h14);
      repeat (2) @(negedge clk);
      check("no queued move", {63'd0, busy}, 64'd0);
      check("no queued load", grid, 64'h14);

      // Load wins over a simultaneous move.
      @(negedge clk);
      load = 1'b1;
      load_grid = 64'h300;
      btn_left = 1'b1;
      @(negedge clk);
      load = 1'b0;
      btn_left = 1'b0;
      check("load prio busy", {63'd0, busy}, 64'd0);
      check("load prio grid", grid, 64'h300);
      @(negedge clk);
      check("load prio idle", {63'd0, busy}, 64'd0);

      // Reset asserted in the middle of a slide.
      do_load(64'h2211);
      @(negedge clk);
      btn_left = 1'b1;
      @(negedge clk);
      btn_left = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst grid", grid, 64'd0);
      check("midrst busy", {63'd0, busy}, 64'd1);
      check("midrst won", {63'd0, won}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle(cnt);
      check("midrst busy cycles", 64'(cnt), 64'd5);
      check("midrst grid after", grid, 64'h11);

      // Random boards, moves and rng against the reference model.
      won_exp = 1'b0;
      for (int it = 0; it < 40; it++) begin
         for (int c = 0; c < 16; c++) begin
            r = $urandom_range(0, 15);
            b[c*4 +: 4] = (r < 6) ? 4'd0 : 4'(r - 5);
         end
         rn = 5'($urandom_range(0, 31));
         bt = 4'($urandom_range(1, 15));
         d  = bt[3] ? 0 : bt[2] ? 1 : bt[1] ? 2 : 3;
         mv = ref_move(b, d);
         if (mv != b) begin
            exp_g = ref_spawn(mv, rn, sc);
            eb = 5 + sc;
            if (ref_win(exp_g)) won_exp = 1'b1;
         end else begin
            exp_g = b;
            eb = 4;
         end
         rng = rn;
         do_load(b);
         check($sformatf("r%0d load", it), grid, b);
         do_move(bt, cnt);
         check($sformatf("r%0d busy cycles", it), 64'(cnt), 64'(eb));
         check($sformatf("r%0d grid", it), grid, exp_g);
         check($sformatf("r%0d won", it), {63'd0, won}, {63'd0, won_exp});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
